// File: rtl/tpu_pkg.sv
// Purpose: shared types and defaults for the systolic-array datapath blocks.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package tpu_pkg;

    localparam int N_DEF     = 4;
    localparam int ACC_W_DEF = 16;

    // Result collector control state.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        DONE    = 2'd2
    } collector_state_t;

endpackage

// File: rtl/collector_column.sv
// Purpose: per-column beat counter for the result collector; picks the row each beat lands in.
// Latency: combinational write enable and row select; the counter updates on the next edge.
// Backpressure: none. A beat arriving at a full column is dropped and flagged on col_ovf.
//
// Ports:
//   clk, reset       clock and synchronous active-high reset
//   clear            restart: the counter returns to zero, and same-cycle beats are ignored
//   collect          parent is in COLLECT, so beats may be accepted
//   beat_vld         psum_valid bit for this column
//   wr_en, wr_row    store this column's beat at row wr_row of the buffer
//   full_next        the column holds N elements after the current edge
//   col_ovf          beat dropped because the column was already full
module collector_column #(
    parameter int N = 4,
    localparam int CW = $clog2(N) + 1,
    localparam int RW = $clog2(N)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clear,
    input  logic          collect,
    input  logic          beat_vld,
    output logic          wr_en,
    output logic [RW-1:0] wr_row,
    output logic          full_next,
    output logic          col_ovf
);

    localparam logic [CW-1:0] FULL_CNT = CW'(N);
    localparam logic [CW-1:0] LAST_CNT = CW'(N - 1);

    logic [CW-1:0] cnt_q;
    logic          full;
    logic          accept;

    assign full    = (cnt_q == FULL_CNT);
    assign accept  = collect & ~clear & beat_vld;
    assign wr_en   = accept & ~full;
    assign col_ovf = accept & full;
    // The counter never passes N, so its low bits are the next free row.
    assign wr_row  = cnt_q[RW-1:0];
    assign full_next = full | (wr_en & (cnt_q == LAST_CNT));

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            cnt_q <= '0;
        end else if (wr_en) begin
            cnt_q <= cnt_q + CW'(1);
        end
    end

endmodule

// File: rtl/result_collector.sv
// Purpose: reassemble skewed per-column partial-sum beats from the array's bottom row into an NxN matrix.
// Latency: result_valid rises one cycle after the last beat is sampled. result_out is driven directly by a register.
// Backpressure: result_valid/result_ready. The matrix holds in DONE, and beats that arrive outside COLLECT are dropped and flagged.
//
// Ports:
//   clk, reset              clock and synchronous active-high reset
//   start                   clear the buffer and arm a collection; ignored in DONE unless result_ready
//   psum_valid, psum_in     per-column beats; psum_in[j] belongs to column j
//   result_valid/_ready     matrix handshake toward the output buffer
//   result_out              element (r,c) at [(N*r+c)*ACC_W +: ACC_W]
//   busy                    high while collecting
//   overflow_err            sticky dropped-beat flag; cleared by reset or by an accepted start
module result_collector
    import tpu_pkg::*;
#(
    parameter int N     = N_DEF,
    parameter int ACC_W = ACC_W_DEF
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic [N-1:0]              psum_valid,
    input  logic [N-1:0][ACC_W-1:0]   psum_in,
    output logic                      result_valid,
    input  logic                      result_ready,
    output logic [ACC_W*N*N-1:0]      result_out,
    output logic                      busy,
    output logic                      overflow_err
);

    localparam int RW = $clog2(N);

    collector_state_t state_q, state_d;

    logic                          clear;
    logic                          collect;
    logic                          stray_beat;
    logic [N-1:0]                  wr_en;
    logic [N-1:0]                  full_next;
    logic [N-1:0]                  col_ovf;
    logic [N-1:0][RW-1:0]          wr_row;
    // The buffer is indexed [row][col], so its packed layout matches result_out.
    logic [N-1:0][N-1:0][ACC_W-1:0] buf_q;

    assign collect    = (state_q == COLLECT);
    // A start in DONE counts only when the current matrix is handed off in the same cycle.
    assign clear      = start & ((state_q != DONE) | result_ready);
    assign stray_beat = ~collect & (|psum_valid);
    assign result_out = buf_q;

    for (genvar j = 0; j < N; j++) begin : g_col
        collector_column #(.N(N)) u_col (
            .clk       (clk),
            .reset     (reset),
            .clear     (clear),
            .collect   (collect),
            .beat_vld  (psum_valid[j]),
            .wr_en     (wr_en[j]),
            .wr_row    (wr_row[j]),
            .full_next (full_next[j]),
            .col_ovf   (col_ovf[j])
        );
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        result_valid = 1'b0;
        busy         = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) state_d = COLLECT;
            end
            COLLECT: begin
                busy = 1'b1;
                // A restart keeps the block in COLLECT, even if the columns were about to fill.
                if (!start && (&full_next)) state_d = DONE;
            end
            DONE: begin
                result_valid = 1'b1;
                if (result_ready) state_d = start ? COLLECT : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            buf_q <= '0;
        end else begin
            for (int j = 0; j < N; j++) begin
                if (wr_en[j]) buf_q[wr_row[j]][j] <= psum_in[j];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            overflow_err <= 1'b0;
        end else if (stray_beat || (|col_ovf)) begin
            overflow_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_result_collector.sv
module tb_result_collector;

    localparam int N = 4;
    localparam int W = 16;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 start;
    logic [N-1:0]         psum_valid;
    logic [N-1:0][W-1:0]  psum_in;
    logic                 result_valid;
    logic                 result_ready;
    logic [W*N*N-1:0]     result_out;
    logic                 busy;
    logic                 overflow_err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    result_collector #(.N(N), .ACC_W(W)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .psum_valid   (psum_valid),
        .psum_in      (psum_in),
        .result_valid (result_valid),
        .result_ready (result_ready),
        .result_out   (result_out),
        .busy         (busy),
        .overflow_err (overflow_err)
    );

    typedef struct {
        logic       st;
        logic [3:0] vld;
        logic       rdy;
        logic       ev;
        logic       eb;
        logic       eo;
        int         mat;   // 0: skip, 1: expect 16*r+c, 2: expect all zero
    } vec_t;

    vec_t vq[$];
    int   kcnt[N];

    // Reference model: beats received so far per column, plus the matrix they build.
    logic        m_col, m_done, m_ovf;
    int          m_cnt[N];
    logic [W-1:0] m_mat[N][N];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [255:0] ref_matrix();
        logic [255:0] m;
        m = '0;
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++)
                m[(N*r+c)*W +: W] = 16'(16*r + c);
        return m;
    endfunction

    function automatic logic [255:0] model_matrix();
        logic [255:0] m;
        m = '0;
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++)
                m[(N*r+c)*W +: W] = m_mat[r][c];
        return m;
    endfunction

    task automatic add(input logic st, input logic [3:0] v, input logic rdy,
                       input logic ev, input logic eb, input logic eo, input int mat);
        vec_t x;
        x.st = st; x.vld = v; x.rdy = rdy; x.ev = ev; x.eb = eb; x.eo = eo; x.mat = mat;
        vq.push_back(x);
    endtask

    task automatic model_clear();
        for (int j = 0; j < N; j++) m_cnt[j] = 0;
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++) m_mat[r][c] = '0;
    endtask

    // Advance the model by one clock edge, using the inputs currently applied.
    task automatic model_step();
        logic clr;
        bit   all;
        if (reset) begin
            m_col = 0; m_done = 0; m_ovf = 0;
            model_clear();
            return;
        end
        clr = start && (!m_done || result_ready);
        if (clr) begin
            m_col = 1; m_done = 0; m_ovf = 0;
            model_clear();
        end else begin
            for (int j = 0; j < N; j++) begin
                if (psum_valid[j]) begin
                    if (m_col && m_cnt[j] < N) begin
                        m_mat[m_cnt[j]][j] = psum_in[j];
                        m_cnt[j]++;
                    end else begin
                        m_ovf = 1;
                    end
                end
            end
            if (m_col) begin
                all = 1;
                for (int j = 0; j < N; j++) if (m_cnt[j] != N) all = 0;
                if (all) begin m_col = 0; m_done = 1; end
            end else if (m_done && result_ready) begin
                m_done = 0;
            end
        end
    endtask

    task automatic apply_beats(input logic [3:0] v);
        start = 0; psum_valid = v; result_ready = 0;
        for (int j = 0; j < N; j++) begin
            psum_in[j] = 16'(16*kcnt[j] + j);
            if (v[j]) kcnt[j]++;
        end
        step();
    endtask

    initial begin
        reset = 1; start = 0; psum_valid = '0; result_ready = 0; psum_in = '0;
        for (int j = 0; j < N; j++) kcnt[j] = 0;
        step();
        step();
        reset = 0;
        chk("reset valid", result_valid, 0);
        chk("reset busy", busy, 0);
        chk("reset ovf", overflow_err, 0);
        chk("reset buffer", result_out, 0);

        // Aligned collection, then a stalled DONE with stray beats, then accept.
        add(1, 4'b0000, 0, 0, 1, 0, 2);
        add(0, 4'b1111, 0, 0, 1, 0, 0);
        add(0, 4'b1111, 0, 0, 1, 0, 0);
        add(0, 4'b1111, 0, 0, 1, 0, 0);
        add(0, 4'b1111, 0, 1, 0, 0, 1);
        add(0, 4'b0101, 0, 1, 0, 1, 1);
        add(0, 4'b1010, 0, 1, 0, 1, 1);
        add(0, 4'b1111, 0, 1, 0, 1, 1);
        add(0, 4'b0000, 0, 1, 0, 1, 1);
        add(0, 4'b0011, 0, 1, 0, 1, 1);
        add(0, 4'b0000, 1, 0, 0, 1, 1);
        // Array skew: column j valid on cycles j..j+3.
        add(1, 4'b0000, 0, 0, 1, 0, 2);
        add(0, 4'b0001, 0, 0, 1, 0, 0);
        add(0, 4'b0011, 0, 0, 1, 0, 0);
        add(0, 4'b0111, 0, 0, 1, 0, 0);
        add(0, 4'b1111, 0, 0, 1, 0, 0);
        add(0, 4'b1110, 0, 0, 1, 0, 0);
        add(0, 4'b1100, 0, 0, 1, 0, 0);
        add(0, 4'b1000, 0, 1, 0, 0, 1);
        add(0, 4'b0000, 1, 0, 0, 0, 1);
        add(0, 4'b0010, 0, 0, 0, 1, 1);
        // Fifth beat on column 2 while the other columns are incomplete.
        add(1, 4'b0000, 0, 0, 1, 0, 2);
        add(0, 4'b1111, 0, 0, 1, 0, 0);
        add(0, 4'b1111, 0, 0, 1, 0, 0);
        add(0, 4'b1111, 0, 0, 1, 0, 0);
        add(0, 4'b0100, 0, 0, 1, 0, 0);
        add(0, 4'b0100, 0, 0, 1, 1, 0);
        add(0, 4'b1011, 0, 1, 0, 1, 1);
        add(0, 4'b0000, 1, 0, 0, 1, 1);
        // Restart after two beats; same-cycle beats are dropped.
        add(1, 4'b0000, 0, 0, 1, 0, 2);
        add(0, 4'b1111, 0, 0, 1, 0, 0);
        add(0, 4'b1111, 0, 0, 1, 0, 0);
        add(1, 4'b1111, 0, 0, 1, 0, 2);
        add(0, 4'b1111, 0, 0, 1, 0, 0);
        add(0, 4'b1111, 0, 0, 1, 0, 0);
        add(0, 4'b1111, 0, 0, 1, 0, 0);
        add(0, 4'b1111, 0, 1, 0, 0, 1);
        // start together with result_ready in DONE.
        add(1, 4'b0000, 1, 0, 1, 0, 2);
        add(0, 4'b0000, 0, 0, 1, 0, 2);

        foreach (vq[i]) begin
            start = vq[i].st; psum_valid = vq[i].vld; result_ready = vq[i].rdy;
            for (int j = 0; j < N; j++) begin
                psum_in[j] = 16'(16*kcnt[j] + j);
                if (vq[i].st) kcnt[j] = 0;
                else if (vq[i].vld[j]) kcnt[j]++;
            end
            step();
            chk($sformatf("vec%0d result_valid", i), result_valid, vq[i].ev);
            chk($sformatf("vec%0d busy", i), busy, vq[i].eb);
            chk($sformatf("vec%0d overflow_err", i), overflow_err, vq[i].eo);
            if (vq[i].mat == 1) chk($sformatf("vec%0d matrix", i), result_out, ref_matrix());
            else if (vq[i].mat == 2) chk($sformatf("vec%0d zero buffer", i), result_out, 0);
        end

        // Reset in the middle of a collection; the counters must start again from zero.
        apply_beats(4'b1111);
        apply_beats(4'b1111);
        reset = 1; psum_valid = 4'b1111;
        step();
        reset = 0; psum_valid = '0;
        chk("midreset valid", result_valid, 0);
        chk("midreset busy", busy, 0);
        chk("midreset ovf", overflow_err, 0);
        chk("midreset buffer", result_out, 0);
        start = 1;
        for (int j = 0; j < N; j++) kcnt[j] = 0;
        step();
        apply_beats(4'b1111);
        apply_beats(4'b1111);
        apply_beats(4'b1111);
        chk("postreset not early", result_valid, 0);
        apply_beats(4'b1111);
        chk("postreset valid", result_valid, 1);
        chk("postreset matrix", result_out, ref_matrix());

        // Randomized traffic against the model.
        reset = 1; start = 0; psum_valid = '0; result_ready = 0;
        model_step();
        step();
        for (int cyc = 0; cyc < 1500; cyc++) begin
            reset        = ($urandom_range(0, 299) == 0);
            start        = ($urandom_range(0, 15) == 0);
            psum_valid   = ($urandom_range(0, 1) == 0) ? 4'hF : 4'($urandom);
            result_ready = ($urandom_range(0, 2) == 0);
            for (int j = 0; j < N; j++) psum_in[j] = 16'($urandom);
            model_step();
            step();
            chk("rand result_valid", result_valid, m_done);
            chk("rand busy", busy, m_col);
            chk("rand overflow_err", overflow_err, m_ovf);
            chk("rand result_out", result_out, model_matrix());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
